// File: rtl/edge_trigger_multi.sv
// edge_trigger_multi
// Multi-channel edge detector and trigger qualifier for the ILA capture path.
// Each probe channel is synchronised, edge-detected and matched against a
// per-channel condition; channel matches are combined with AND or OR, and a
// single trigger pulse is issued once a programmable number of hits has been
// counted since the last arm.

module edge_trigger_multi #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [WIDTH-1:0]     i_signal,
  input  logic [3*WIDTH-1:0]   i_mode,
  input  logic                 i_combine,
  input  logic [CNT_W-1:0]     i_count_target,
  input  logic                 i_arm,
  input  logic                 i_disarm,
  output logic [WIDTH-1:0]     o_posedge,
  output logic [WIDTH-1:0]     o_negedge,
  output logic                 o_armed,
  output logic                 o_trigger,
  output logic                 o_triggered,
  output logic [CNT_W-1:0]     o_hit_count
);

  // Per-channel condition codes.
  localparam logic [2:0] MODE_RISE  = 3'd1;
  localparam logic [2:0] MODE_FALL  = 3'd2;
  localparam logic [2:0] MODE_EDGE  = 3'd3;
  localparam logic [2:0] MODE_HIGH  = 3'd4;
  localparam logic [2:0] MODE_LOW   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMED     = 2'd1,
    S_TRIGGERED = 2'd2
  } state_t;

  logic [WIDTH-1:0]   cur;
  logic [WIDTH-1:0]   prev;

  state_t             state_q;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_next;
  logic               fire;
  logic               latch_cfg;

  logic [3*WIDTH-1:0] mode_q;
  logic               combine_q;
  logic [CNT_W-1:0]   target_q;
  logic [CNT_W-1:0]   target_eff;
  logic [CNT_W:0]     cnt_inc;

  logic [WIDTH-1:0]   ch_en;
  logic [WIDTH-1:0]   ch_match;
  logic               hit;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign cur = i_signal;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      // Shift the probe channels through the synchroniser chain.
      always_ff @(posedge i_clk) begin
        // NOTE: reset preloads the chain with the live input rather than zero,
        // so a channel that is already high does not look like a rising edge
        // on the first cycles after reset release.
        if (i_reset) begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= i_signal;
          end
        end else begin
          sync_q[0] <= i_signal;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
          end
        end
      end

      assign cur = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------

  // Register the previous sample and the one-cycle edge pulses.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop in
    // this block samples the values from before the clock edge.
    if (i_reset) begin
      prev      <= i_signal;
      o_posedge <= '0;
      o_negedge <= '0;
    end else begin
      prev      <= cur;
      o_posedge <= cur & ~prev;
      o_negedge <= ~cur & prev;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel qualification
  // ---------------------------------------------------------------------------

  // Evaluate each channel's latched condition against the same cur/prev pair
  // that feeds the edge outputs, so hit lines up with o_posedge/o_negedge.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    ch_en    = '0;
    ch_match = '0;
    for (int n = 0; n < WIDTH; n++) begin
      case (mode_q[3*n +: 3])
        MODE_RISE: begin
          ch_en[n]    = 1'b1;
          ch_match[n] = cur[n] & ~prev[n];
        end
        MODE_FALL: begin
          ch_en[n]    = 1'b1;
          ch_match[n] = ~cur[n] & prev[n];
        end
        MODE_EDGE: begin
          ch_en[n]    = 1'b1;
          ch_match[n] = cur[n] ^ prev[n];
        end
        MODE_HIGH: begin
          ch_en[n]    = 1'b1;
          ch_match[n] = cur[n];
        end
        MODE_LOW: begin
          ch_en[n]    = 1'b1;
          ch_match[n] = ~cur[n];
        end
        default: begin
          ch_en[n]    = 1'b0;
          ch_match[n] = 1'b0;
        end
      endcase
    end
  end

  // Combine enabled channels; with nothing enabled there is never a hit.
  always_comb begin
    hit = 1'b0;
    if (|ch_en) begin
      if (combine_q) begin
        hit = &(ch_match | ~ch_en);
      end else begin
        hit = |(ch_match & ch_en);
      end
    end
  end

  // A target of zero behaves as a target of one.
  assign target_eff = (target_q == '0) ? CNT_W'(1) : target_q;
  assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // ---------------------------------------------------------------------------
  // Trigger FSM
  // ---------------------------------------------------------------------------

  // State, counter, latched configuration and the registered trigger pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      combine_q <= 1'b0;
      target_q  <= '0;
      o_trigger <= 1'b0;
    end else begin
      state_q   <= state_next;
      cnt_q     <= cnt_next;
      o_trigger <= fire;
      if (latch_cfg) begin
        mode_q    <= i_mode;
        combine_q <= i_combine;
        target_q  <= i_count_target;
      end
    end
  end

  // Next-state logic: disarm beats arm, arm (re)starts from any state, and
  // hits are only counted while armed and not in the arm cycle itself.
  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    fire       = 1'b0;
    latch_cfg  = 1'b0;
    if (i_disarm) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end else if (i_arm) begin
      state_next = S_ARMED;
      cnt_next   = '0;
      latch_cfg  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_next = S_IDLE;
        end
        S_ARMED: begin
          if (hit) begin
            if (cnt_inc == {1'b0, target_eff}) begin
              state_next = S_TRIGGERED;
              cnt_next   = target_eff;
              fire       = 1'b1;
            end else begin
              cnt_next = cnt_inc[CNT_W-1:0];
            end
          end
        end
        S_TRIGGERED: begin
          state_next = S_TRIGGERED;
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    o_armed     = (state_q == S_ARMED);
    o_triggered = (state_q == S_TRIGGERED);
    o_hit_count = cnt_q;
  end

endmodule

// File: tb/tb_edge_trigger_multi.sv
// tb_edge_trigger_multi
// Directed bench for edge_trigger_multi (WIDTH=8, SYNC_STAGES=2, CNT_W=8).
// Inputs change 1 ns after a rising edge and outputs are sampled at the same
// point, so each tick() observes the registers loaded on that edge.

module tb_edge_trigger_multi;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     sig;
  logic [3*WIDTH-1:0]   mode;
  logic                 combine;
  logic [CNT_W-1:0]     target;
  logic                 arm;
  logic                 disarm;
  logic [WIDTH-1:0]     pe;
  logic [WIDTH-1:0]     ne;
  logic                 armed;
  logic                 trig;
  logic                 triggered;
  logic [CNT_W-1:0]     hits;

  int n_total = 0;
  int n_bad   = 0;
  int trig_seen;

  edge_trigger_multi #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_signal       (sig),
    .i_mode         (mode),
    .i_combine      (combine),
    .i_count_target (target),
    .i_arm          (arm),
    .i_disarm       (disarm),
    .o_posedge      (pe),
    .o_negedge      (ne),
    .o_armed        (armed),
    .o_trigger      (trig),
    .o_triggered    (triggered),
    .o_hit_count    (hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance n cycles and count trigger pulses seen along the way.
  task automatic ticks_count_trig(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (trig) trig_seen++;
    end
  endtask

  task automatic do_arm(input logic [3*WIDTH-1:0] m, input logic c, input logic [CNT_W-1:0] t);
    mode    = m;
    combine = c;
    target  = t;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
  endtask

  // Watchdog: the bench uses fixed cycle counts, this only guards a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    sig     = 8'hFF;
    mode    = '0;
    combine = 1'b0;
    target  = '0;
    arm     = 1'b0;
    disarm  = 1'b0;

    // ---- Reset state, release with all channels high ----
    ticks(3);
    check("rst_posedge",   32'(pe),        32'h0);
    check("rst_negedge",   32'(ne),        32'h0);
    check("rst_armed",     32'(armed),     32'h0);
    check("rst_trigger",   32'(trig),      32'h0);
    check("rst_triggered", 32'(triggered), 32'h0);
    check("rst_hits",      32'(hits),      32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rel_no_pe", 32'(pe), 32'h0);
      check("rel_no_ne", 32'(ne), 32'h0);
    end

    // ---- Edge latency: ch0 0->1 pulses exactly 3 cycles later ----
    sig = 8'h00;
    ticks(6);
    sig = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("lat_pe_k%0d", k), 32'(pe), (k == 3) ? 32'h1 : 32'h0);
      check($sformatf("lat_ne_k%0d", k), 32'(ne), 32'h0);
    end

    // ---- ch0 rising / ch1 falling, OR, target 1 ----
    sig = 8'h00;
    ticks(5);
    do_arm(24'h000011, 1'b0, 8'd1);
    check("or_armed", 32'(armed), 32'h1);
    check("or_hits0", 32'(hits),  32'h0);
    sig = 8'h01;
    ticks(2);
    check("or_pre_trig", 32'(trig), 32'h0);
    tick();
    check("or_trig",      32'(trig),      32'h1);
    check("or_pe0",       32'(pe),        32'h1);
    check("or_triggered", 32'(triggered), 32'h1);
    check("or_armed_off", 32'(armed),     32'h0);
    check("or_hits1",     32'(hits),      32'h1);
    tick();
    check("or_trig_1cyc", 32'(trig), 32'h0);
    trig_seen = 0;
    sig = 8'h03;
    ticks_count_trig(4);
    sig = 8'h00;
    ticks_count_trig(4);
    sig = 8'h01;
    ticks_count_trig(4);
    check("or_no_retrig", 32'(trig_seen), 32'h0);
    check("or_hits_hold", 32'(hits),      32'h1);

    // ---- AND: ch0 level high, ch3 either edge, target 3 ----
    sig = 8'h00;
    ticks(5);
    do_arm(24'h000604, 1'b1, 8'd3);
    check("and_armed", 32'(armed), 32'h1);
    sig = 8'h08;                       // ch3 edge while ch0 low
    ticks(3);
    check("and_pe3_seen",  32'(pe),   32'h08);
    check("and_ch0_low",   32'(hits), 32'h0);
    sig = 8'h09;                       // ch0 high, no ch3 edge yet
    ticks(5);
    check("and_level_only", 32'(hits), 32'h0);
    sig = 8'h01;
    ticks(3);
    check("and_ne3_1", 32'(ne),   32'h08);
    check("and_hits1", 32'(hits), 32'h1);
    check("and_trig1", 32'(trig), 32'h0);
    ticks(2);
    sig = 8'h09;
    ticks(3);
    check("and_hits2", 32'(hits), 32'h2);
    check("and_trig2", 32'(trig), 32'h0);
    ticks(2);
    sig = 8'h01;
    ticks(3);
    check("and_hits3",      32'(hits),      32'h3);
    check("and_trig3",      32'(trig),      32'h1);
    check("and_triggered",  32'(triggered), 32'h1);

    // ---- All modes disabled, OR then AND, 50 cycles of toggling ----
    do_arm(24'h000000, 1'b0, 8'd1);
    check("dis_or_armed", 32'(armed), 32'h1);
    trig_seen = 0;
    for (int i = 0; i < 50; i++) begin
      sig = ~sig;
      tick();
      if (trig) trig_seen++;
    end
    check("dis_or_trig", 32'(trig_seen), 32'h0);
    check("dis_or_hits", 32'(hits),      32'h0);
    do_arm(24'h000000, 1'b1, 8'd1);
    trig_seen = 0;
    for (int i = 0; i < 50; i++) begin
      sig = ~sig;
      tick();
      if (trig) trig_seen++;
    end
    check("dis_and_trig",  32'(trig_seen), 32'h0);
    check("dis_and_hits",  32'(hits),      32'h0);
    check("dis_and_armed", 32'(armed),     32'h1);

    // ---- Target 0, level high held at arm ----
    sig = 8'h01;
    ticks(5);
    do_arm(24'h000004, 1'b0, 8'd0);
    check("t0_arm_hits", 32'(hits), 32'h0);
    check("t0_arm_trig", 32'(trig), 32'h0);
    tick();
    check("t0_trig", 32'(trig), 32'h1);
    check("t0_hits", 32'(hits), 32'h1);
    // Re-arm from TRIGGERED: the latched level condition already matches in
    // the arm cycle, which must not be counted.
    do_arm(24'h000004, 1'b0, 8'd0);
    check("t0_rearm_armed", 32'(armed), 32'h1);
    check("t0_rearm_hits",  32'(hits),  32'h0);
    check("t0_rearm_trig",  32'(trig),  32'h0);
    tick();
    check("t0_rearm_fire",  32'(trig),  32'h1);
    check("t0_rearm_cnt",   32'(hits),  32'h1);

    // ---- Arm and disarm together -> IDLE ----
    arm    = 1'b1;
    disarm = 1'b1;
    tick();
    arm    = 1'b0;
    disarm = 1'b0;
    check("armdis_armed",     32'(armed),     32'h0);
    check("armdis_triggered", 32'(triggered), 32'h0);
    check("armdis_hits",      32'(hits),      32'h0);

    // ---- Disarm at 2 of 4 rising edges ----
    sig = 8'h00;
    ticks(5);
    do_arm(24'h000001, 1'b0, 8'd4);
    sig = 8'h01;
    ticks(4);
    check("dis2_hits1", 32'(hits), 32'h1);
    sig = 8'h00;
    ticks(4);
    sig = 8'h01;
    ticks(4);
    check("dis2_hits2", 32'(hits), 32'h2);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    check("dis2_cleared", 32'(hits),  32'h0);
    check("dis2_idle",    32'(armed), 32'h0);
    trig_seen = 0;
    for (int i = 0; i < 3; i++) begin
      sig = 8'h00;
      ticks_count_trig(4);
      sig = 8'h01;
      ticks_count_trig(4);
    end
    check("dis2_no_trig", 32'(trig_seen), 32'h0);
    check("dis2_hits_0",  32'(hits),      32'h0);

    // ---- Reset in ARMED on the cycle the trigger would fire ----
    do_arm(24'h000004, 1'b0, 8'd3);
    tick();
    check("rstmid_hits1", 32'(hits), 32'h1);
    tick();
    check("rstmid_hits2", 32'(hits), 32'h2);
    rst = 1'b1;
    tick();
    check("rstmid_trig",      32'(trig),      32'h0);
    check("rstmid_armed",     32'(armed),     32'h0);
    check("rstmid_triggered", 32'(triggered), 32'h0);
    check("rstmid_hits",      32'(hits),      32'h0);
    check("rstmid_pe",        32'(pe),        32'h0);
    check("rstmid_ne",        32'(ne),        32'h0);
    rst = 1'b0;
    trig_seen = 0;
    ticks_count_trig(5);
    check("rstmid_after_trig",  32'(trig_seen), 32'h0);
    check("rstmid_after_armed", 32'(armed),     32'h0);
    check("rstmid_after_pe",    32'(pe),        32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
